// File: rtl/br_delay_deskew_lanes_pkg.sv
// Shared types for the lane deskew block: the alignment state machine encoding.
package br_delay_deskew_lanes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGNING,
    ALIGNED,
    ERROR
  } state_e;

endpackage

// File: rtl/br_delay_deskew_lane_fifo.sv
// Per-lane flop FIFO used to absorb inter-lane skew; registered occupancy count.
module br_delay_deskew_lane_fifo #(
  parameter int Width = 1,
  parameter int Depth = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic [Width-1:0]             pop_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign count    = count_q;
  assign pop_data = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/br_delay_deskew_lanes.sv
// Multi-lane deskew: buffers early lanes until every lane has data, then pops all in lockstep.
// Optional skew measurement output enabled by BR_DELAY_DESKEW_LANES_SKEW_MEAS_EN.
module br_delay_deskew_lanes
  import br_delay_deskew_lanes_pkg::*;
#(
  parameter int NumLanes = 2,
  parameter int Width    = 1,
  parameter int MaxSkew  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NumLanes-1:0]          in_valid,
  input  logic [NumLanes*Width-1:0]    in_data,
  output logic                         out_valid,
  output logic [NumLanes*Width-1:0]    out_data,
  output logic                         error
`ifdef BR_DELAY_DESKEW_LANES_SKEW_MEAS_EN
  ,
  output logic [$clog2(MaxSkew+1)-1:0] max_skew_seen
`endif
);

  localparam int Depth = MaxSkew + 1;
  localparam int SkewW = $clog2(MaxSkew + 1);
  localparam int CntW  = $clog2(Depth + 1);

  if (NumLanes < 2) begin : g_chk_lanes
    $error("NumLanes must be >= 2");
  end
  if (Width < 1) begin : g_chk_width
    $error("Width must be >= 1");
  end
  if (MaxSkew < 1) begin : g_chk_skew
    $error("MaxSkew must be >= 1");
  end

  state_e                         state_q, state_d;
  logic [SkewW-1:0]               skew_q, skew_d;
  logic [NumLanes-1:0]            push, empty, full, have, nz_nxt;
  logic [NumLanes-1:0][CntW-1:0]  count;
  logic                           pop, overflow, fifo_flush;

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    br_delay_deskew_lane_fifo #(
      .Width(Width),
      .Depth(Depth)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (fifo_flush),
      .push     (push[l]),
      .push_data(in_data[l*Width +: Width]),
      .pop      (pop),
      .pop_data (out_data[l*Width +: Width]),
      .empty    (empty[l]),
      .full     (full[l]),
      .count    (count[l])
    );
  end

  always_comb begin
    out_valid = (state_q == ALIGNED) && (&(~empty));
    pop       = out_valid;
    overflow  = 1'b0;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      push[l]   = in_valid[l] && !flush && (state_q != ERROR);
      have[l]   = !empty[l] || in_valid[l];
      // Lane still holds data after this cycle's pop/push.
      nz_nxt[l] = push[l] || (!empty[l] && !(pop && (count[l] == CntW'(1))));
      if (push[l] && full[l] && !pop) overflow = 1'b1;
    end

    state_d = state_q;
    skew_d  = '0;
    case (state_q)
      IDLE: begin
        if (&in_valid) begin
          state_d = ALIGNED;
        end else if (|in_valid) begin
          state_d = ALIGNING;
          skew_d  = SkewW'(1);
        end
      end
      ALIGNING: begin
        if (&have) begin
          state_d = ALIGNED;
        end else if (skew_q == SkewW'(MaxSkew)) begin
          state_d = ERROR;
        end else begin
          skew_d = skew_q + SkewW'(1);
        end
      end
      ALIGNED: begin
        if (~|nz_nxt) state_d = IDLE;
        else if (~&nz_nxt) state_d = ERROR;
      end
      default: state_d = ERROR;
    endcase

    if (overflow) state_d = ERROR;
    if (flush) begin
      state_d = IDLE;
      skew_d  = '0;
    end
    fifo_flush = flush || (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      skew_q  <= '0;
    end else begin
      state_q <= state_d;
      skew_q  <= skew_d;
    end
  end

  assign error = (state_q == ERROR);

`ifdef BR_DELAY_DESKEW_LANES_SKEW_MEAS_EN
  logic [SkewW-1:0] max_skew_q, max_skew_d;

  always_comb begin
    max_skew_d = max_skew_q;
    if ((state_q == ALIGNING) && (state_d == ALIGNED) && (skew_q > max_skew_q))
      max_skew_d = skew_q;
    if (flush) max_skew_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) max_skew_q <= '0;
    else        max_skew_q <= max_skew_d;
  end

  assign max_skew_seen = max_skew_q;
`endif

  a_valid_no_err: assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> !error);

endmodule

// File: tb/tb_br_delay_deskew_lanes.sv
// Self-checking bench for br_delay_deskew_lanes: queue-based reference model plus directed scenarios.
module tb_br_delay_deskew_lanes;

  localparam int NL    = 2;
  localparam int W     = 4;
  localparam int MS    = 4;
  localparam int DEPTH = MS + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [NL-1:0]   in_valid = '0;
  logic [NL*W-1:0] in_data = '0;
  logic            out_valid;
  logic [NL*W-1:0] out_data;
  logic            error;
`ifdef BR_DELAY_DESKEW_LANES_SKEW_MEAS_EN
  logic [2:0]      max_skew_seen;
`endif

  always #5 clk = ~clk;

  br_delay_deskew_lanes #(
    .NumLanes(NL),
    .Width   (W),
    .MaxSkew (MS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .error    (error)
`ifdef BR_DELAY_DESKEW_LANES_SKEW_MEAS_EN
    ,
    .max_skew_seen(max_skew_seen)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: per-lane queues, mode, and burst start cycle for skew.
  typedef enum {M_IDLE, M_ALIGNING, M_ALIGNED, M_ERROR} mmode_e;
  logic [W-1:0] mq [NL][$];
  mmode_e       mmode = M_IDLE;
  int           mcyc = 0, mstart = 0, mmax = 0;
  bit           known = 0;

  function automatic bit m_ov();
    bit ok = (mmode == M_ALIGNED);
    for (int l = 0; l < NL; l++) if (mq[l].size() == 0) ok = 0;
    return ok;
  endfunction

  task automatic m_clear();
    for (int l = 0; l < NL; l++) mq[l].delete();
  endtask

  task automatic model_step(input bit r, input bit f, input logic [NL-1:0] v,
                            input logic [NL*W-1:0] d);
    bit ov, bad, all_ne, any_ne, all_v, any_v;
    if (!r) begin
      m_clear(); mmode = M_IDLE; mmax = 0; known = 1;
    end else if (!known) begin
    end else if (f) begin
      m_clear(); mmode = M_IDLE; mmax = 0;
    end else if (mmode != M_ERROR) begin
      ov = m_ov();
      if (ov) for (int l = 0; l < NL; l++) void'(mq[l].pop_front());
      bad = 0;
      for (int l = 0; l < NL; l++) if (v[l] && mq[l].size() == DEPTH) bad = 1;
      if (bad) begin
        mmode = M_ERROR;
      end else begin
        for (int l = 0; l < NL; l++) if (v[l]) mq[l].push_back(d[l*W +: W]);
        all_ne = 1; any_ne = 0; all_v = &v; any_v = |v;
        for (int l = 0; l < NL; l++) begin
          if (mq[l].size() == 0) all_ne = 0;
          else any_ne = 1;
        end
        case (mmode)
          M_IDLE: begin
            if (all_v) mmode = M_ALIGNED;
            else if (any_v) begin mmode = M_ALIGNING; mstart = mcyc; end
          end
          M_ALIGNING: begin
            if (all_ne) begin
              mmode = M_ALIGNED;
              if (mcyc - mstart > mmax) mmax = mcyc - mstart;
            end else if (mcyc - mstart >= MS) mmode = M_ERROR;
          end
          M_ALIGNED: begin
            if (!any_ne) mmode = M_IDLE;
            else if (!all_ne) mmode = M_ERROR;
          end
          default: ;
        endcase
      end
      if (mmode == M_ERROR) m_clear();
    end
    mcyc++;
  endtask

  task automatic compare();
    bit ov;
    if (!known) return;
    ov = m_ov();
    chk("out_valid", out_valid, ov);
    chk("error", error, mmode == M_ERROR);
    if (ov) for (int l = 0; l < NL; l++) chk("out_data", out_data[l*W +: W], mq[l][0]);
`ifdef BR_DELAY_DESKEW_LANES_SKEW_MEAS_EN
    chk("max_skew_seen", max_skew_seen, mmax);
`endif
  endtask

  logic            rec_ov  [64];
  logic            rec_err [64];
  logic [NL*W-1:0] rec_dat [64];
  int              rc = 0;

  task automatic tick(input bit r, input bit f, input logic [NL-1:0] v,
                      input logic [NL*W-1:0] d);
    @(negedge clk);
    compare();
    if (rc < 64) begin
      rec_ov[rc] = out_valid; rec_err[rc] = error; rec_dat[rc] = out_data;
    end
    rc++;
    rst_n = r; flush = f; in_valid = v; in_data = d;
    model_step(r, f, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, '0, '0);
  endtask

  task automatic start_scn();
    tick(1, 1, '0, '0);
    idle(1);
    rc = 0;
  endtask

  function automatic int ov_sum(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(rec_ov[i]);
    return s;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int len, ln[NL], off[NL];
    logic [NL-1:0] v;
    logic [NL*W-1:0] d;
    bit r;

    tick(0, 0, '0, '0);
    tick(0, 0, '0, '0);
    idle(1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_error", error, 0);

    // Aligned two-word burst
    start_scn();
    tick(1, 0, 2'b11, 8'hAA);
    tick(1, 0, 2'b11, 8'hBB);
    idle(3);
    chk("s1_ov0", rec_ov[0], 0);
    chk("s1_ov1", rec_ov[1], 1);
    chk("s1_d1", rec_dat[1], 8'hAA);
    chk("s1_ov2", rec_ov[2], 1);
    chk("s1_d2", rec_dat[2], 8'hBB);
    chk("s1_ov3", rec_ov[3], 0);

    // Skew of exactly MaxSkew is accepted
    start_scn();
    tick(1, 0, 2'b01, 8'h01);
    tick(1, 0, 2'b01, 8'h02);
    tick(1, 0, 2'b01, 8'h03);
    idle(1);
    tick(1, 0, 2'b10, 8'h10);
    tick(1, 0, 2'b10, 8'h20);
    tick(1, 0, 2'b10, 8'h30);
    idle(3);
    chk("s2_ov4", rec_ov[4], 0);
    chk("s2_ov5", rec_ov[5], 1);
    chk("s2_d5", rec_dat[5], 8'h11);
    chk("s2_d6", rec_dat[6], 8'h22);
    chk("s2_d7", rec_dat[7], 8'h33);
    chk("s2_ov8", rec_ov[8], 0);
    chk("s2_err8", rec_err[8], 0);
`ifdef BR_DELAY_DESKEW_LANES_SKEW_MEAS_EN
    chk("s2_max_skew", max_skew_seen, 4);
`endif

    // Skew of MaxSkew+1 is rejected
    start_scn();
    tick(1, 0, 2'b01, 8'h05);
    idle(4);
    tick(1, 0, 2'b10, 8'h50);
    idle(3);
    chk("s3_err4", rec_err[4], 0);
    chk("s3_err5", rec_err[5], 1);
    chk("s3_ov_none", ov_sum(0, 8), 0);

    // Unequal burst lengths
    start_scn();
    tick(1, 0, 2'b11, 8'h11);
    tick(1, 0, 2'b11, 8'h22);
    tick(1, 0, 2'b01, 8'h03);
    idle(3);
    chk("s4_ov_count", ov_sum(0, 5), 2);
    chk("s4_err2", rec_err[2], 0);
    chk("s4_err3", rec_err[3], 1);

    // Sticky error cleared by flush, then a new burst
    start_scn();
    tick(1, 0, 2'b01, 8'h01);
    idle(9);
    tick(1, 1, 2'b11, 8'hFF);
    idle(1);
    tick(1, 0, 2'b11, 8'h77);
    idle(2);
    chk("s5_err9", rec_err[9], 1);
    chk("s5_err10", rec_err[10], 1);
    chk("s5_err11", rec_err[11], 0);
    chk("s5_ov12", rec_ov[12], 0);
    chk("s5_ov13", rec_ov[13], 1);
    chk("s5_d13", rec_dat[13], 8'h77);

    // Reset in the middle of a skewed burst
    start_scn();
    tick(1, 0, 2'b01, 8'h01);
    tick(1, 0, 2'b01, 8'h02);
    tick(0, 0, 2'b01, 8'h03);
    idle(2);
    tick(1, 0, 2'b11, 8'h55);
    idle(2);
    chk("s6_ov_none", ov_sum(0, 5), 0);
    chk("s6_err3", rec_err[3], 0);
    chk("s6_ov6", rec_ov[6], 1);
    chk("s6_d6", rec_dat[6], 8'h55);

    // Randomized bursts with random skew, length mismatch, flush and reset
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 3) == 0) tick(1, 1, '0, '0);
      len = $urandom_range(1, 4);
      for (int l = 0; l < NL; l++) begin
        off[l] = $urandom_range(0, MS + 1);
        ln[l]  = len;
      end
      off[$urandom_range(0, NL - 1)] = 0;
      if ($urandom_range(0, 5) == 0) ln[$urandom_range(0, NL - 1)] = len + 1;
      for (int t = 0; t < 12; t++) begin
        for (int l = 0; l < NL; l++) v[l] = (t >= off[l]) && (t < off[l] + ln[l]);
        d = NL*W'($urandom);
        r = ($urandom_range(0, 99) != 0);
        tick(r, 0, v, d);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
